// File: rtl/spi_param_regs.sv
// rtl/spi_param_regs.sv - SPI mode-0 slave deframer and atomic parameter register bank
module spi_param_regs #(
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter int         SYNC_STAGES = 2,
  parameter int         FRAME_BITS  = 56
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_sck,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic [7:0]  pic_dat,
  output logic [23:0] fre_dat,
  output logic [15:0] amp_dat,
  output logic        SPI_OK,
  output logic        frame_done,
  output logic        frame_err
);

  localparam int               CNT_W    = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_dly_q, sck_dly_d;
  logic                   cs_dly_q, cs_dly_d;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]  shreg_q, shreg_d;
  logic [7:0]             status_q, status_d;
  logic                   miso_q, miso_d;
  logic [7:0]             pic_q, pic_d;
  logic [23:0]            fre_q, fre_d;
  logic [15:0]            amp_q, amp_d;
  logic                   ok_q, ok_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   last_err_q, last_err_d;
  logic [5:0]             frame_cnt_q, frame_cnt_d;

  logic sck_s, cs_n_s, mosi_s;
  logic sck_rise, sck_fall, cs_fall, cs_rise;
  logic frame_valid;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign cs_n_s = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_dly_q;
  assign sck_fall = ~sck_s & sck_dly_q;
  assign cs_fall  = ~cs_n_s & cs_dly_q;
  assign cs_rise  = cs_n_s & ~cs_dly_q;

  assign frame_valid = (bit_cnt_q == CNT_FULL) &&
                       (shreg_q[FRAME_BITS-1 -: 8] == HEADER);

  // Synchroniser chains plus one extra flop per line for edge detection
  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    sck_dly_d   = sck_s;
    cs_dly_d    = cs_n_s;
  end

  // Frame FSM: shift bits while selected, judge the frame for one cycle after deselect
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    status_d    = status_q;
    miso_d      = miso_q;
    pic_d       = pic_q;
    fre_d       = fre_q;
    amp_d       = amp_q;
    ok_d        = ok_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    last_err_d  = last_err_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        miso_d    = 1'b0;
        if (cs_fall) begin
          state_d  = SHIFT;
          // MSB of the status byte goes out immediately; the rest queue behind it
          miso_d   = ok_q;
          status_d = {last_err_q, frame_cnt_q, 1'b0};
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = CHECK;
          miso_d  = 1'b0;
        end else begin
          if (sck_rise) begin
            shreg_d = {shreg_q[FRAME_BITS-2:0], mosi_s};
            if (bit_cnt_q != CNT_SAT) bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
          // Zero fill means MISO naturally reads 0 once the status byte is spent
          if (sck_fall) begin
            miso_d   = status_q[7];
            status_d = {status_q[6:0], 1'b0};
          end
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (frame_valid) begin
          pic_d       = shreg_q[47:40];
          fre_d       = shreg_q[39:16];
          amp_d       = shreg_q[15:0];
          ok_d        = 1'b1;
          done_d      = 1'b1;
          last_err_d  = 1'b0;
          frame_cnt_d = frame_cnt_q + 6'd1;
        end else if (bit_cnt_q != '0) begin
          err_d      = 1'b1;
          last_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; chip-select synchroniser resets to the deselected level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_dly_q   <= 1'b0;
      cs_dly_q    <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      status_q    <= '0;
      miso_q      <= 1'b0;
      pic_q       <= '0;
      fre_q       <= '0;
      amp_q       <= '0;
      ok_q        <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      last_err_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_dly_q   <= sck_dly_d;
      cs_dly_q    <= cs_dly_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      status_q    <= status_d;
      miso_q      <= miso_d;
      pic_q       <= pic_d;
      fre_q       <= fre_d;
      amp_q       <= amp_d;
      ok_q        <= ok_d;
      done_q      <= done_d;
      err_q       <= err_d;
      last_err_q  <= last_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign spi_miso   = miso_q;
  assign pic_dat    = pic_q;
  assign fre_dat    = fre_q;
  assign amp_dat    = amp_q;
  assign SPI_OK     = ok_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_spi_param_regs.sv
// tb/tb_spi_param_regs.sv - scoreboard bench for spi_param_regs with randomized frames
module tb_spi_param_regs;

  localparam int HALF = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        spi_sck;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic [7:0]  pic_dat;
  logic [23:0] fre_dat;
  logic [15:0] amp_dat;
  logic        SPI_OK;
  logic        frame_done;
  logic        frame_err;

  spi_param_regs dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_sck    (spi_sck),
    .spi_cs_n   (spi_cs_n),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .pic_dat    (pic_dat),
    .fre_dat    (fre_dat),
    .amp_dat    (amp_dat),
    .SPI_OK     (SPI_OK),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    logic [7:0]  pic;
    logic [23:0] fre;
    logic [15:0] amp;
    bit          ok;
  } exp_t;

  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;

  logic [7:0]  m_pic;
  logic [23:0] m_fre;
  logic [15:0] m_amp;
  bit          m_ok;
  bit          m_err;
  logic [5:0]  m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_pic = '0; m_fre = '0; m_amp = '0;
    m_ok = 1'b0; m_err = 1'b0; m_cnt = '0;
  endtask

  // Reference behaviour of a completed frame of nbits bits (MSB first in data)
  task automatic model_commit(input logic [63:0] data, input int nbits);
    exp_t e;
    if (nbits == 0) return;
    if (nbits == 56 && data[55:48] == 8'hA5) begin
      m_pic = data[47:40];
      m_fre = data[39:16];
      m_amp = data[15:0];
      m_ok  = 1'b1;
      m_err = 1'b0;
      m_cnt = m_cnt + 6'd1;
      e.is_done = 1'b1;
    end else begin
      m_err = 1'b1;
      e.is_done = 1'b0;
    end
    e.pic = m_pic; e.fre = m_fre; e.amp = m_amp; e.ok = m_ok;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [63:0] data, input int nbits, input bit chk_lat);
    logic [7:0] exp_s;
    logic [7:0] got_s;
    exp_s = {m_ok, m_err, m_cnt};
    got_s = '0;
    spi_cs_n = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = data[nbits-1-i];
      repeat (HALF) @(posedge clk);
      #1;
      if (i < 8) got_s[7-i] = spi_miso;
      if (i == 8) check("miso_after_status", spi_miso, 0);
      spi_sck = 1'b1;
      repeat (HALF) @(posedge clk);
      #1;
      spi_sck = 1'b0;
    end
    repeat (HALF) @(posedge clk);
    #1;
    spi_cs_n = 1'b1;
    model_commit(data, nbits);
    if (nbits >= 8) check("miso_status", got_s, exp_s);
    if (chk_lat) begin
      repeat (3) @(posedge clk);
      #1;
      check("latency_not_early", frame_done, 0);
      @(posedge clk);
      #1;
      check("latency_done", frame_done, 1);
      check("latency_amp", amp_dat, m_amp);
    end
    repeat (12) @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mk(input logic [7:0] hdr, input logic [7:0] pic,
                                     input logic [23:0] fre, input logic [15:0] amp);
    return {8'h00, hdr, pic, fre, amp};
  endfunction

  // Monitor: every pulse must match the oldest expected outcome
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (frame_done === 1'b1 || frame_err === 1'b1)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: done=%0b err=%0b, required no pulse", frame_done, frame_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_done", frame_done, e.is_done);
        check("pulse_err", frame_err, !e.is_done);
        check("pic_dat", pic_dat, e.pic);
        check("fre_dat", fre_dat, e.fre);
        check("amp_dat", amp_dat, e.amp);
        check("spi_ok", SPI_OK, e.ok);
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    logic [63:0] f;
    logic [31:0] r1, r2, r3;
    logic [7:0]  hdr;
    int          kind, n;

    model_reset();
    rst_n = 1'b0; spi_sck = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("reset_pic", pic_dat, 0);
    check("reset_fre", fre_dat, 0);
    check("reset_amp", amp_dat, 0);
    check("reset_spi_ok", SPI_OK, 0);
    check("reset_done", frame_done, 0);
    check("reset_err", frame_err, 0);
    check("reset_miso", spi_miso, 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    send_frame(mk(8'hA5, 8'h01, 24'h002710, 16'h8000), 56, 1'b1);
    check("t2_pic", pic_dat, 8'h01);
    check("t2_fre", fre_dat, 24'h002710);
    check("t2_amp", amp_dat, 16'h8000);
    send_frame(mk(8'h5A, 8'h03, 24'h123456, 16'h4321), 56, 1'b0);
    f = mk(8'hA5, 8'h03, 24'h0ABCDE, 16'h1234);
    send_frame(f >> 1, 55, 1'b0);
    send_frame({f[62:0], 1'b1}, 57, 1'b0);
    check("t4_amp_kept", amp_dat, 16'h8000);
    send_frame(mk(8'hA5, 8'h03, 24'h000100, 16'h7FFF), 56, 1'b0);
    send_frame(64'h0, 0, 1'b0);

    for (int k = 0; k < 24; k++) begin
      r1 = $urandom; r2 = $urandom; r3 = $urandom;
      kind = $urandom_range(0, 4);
      hdr = r3[31:24];
      if (hdr == 8'hA5) hdr = 8'h5A;
      case (kind)
        0, 1: send_frame(mk(8'hA5, r1[7:0], r2[23:0], r3[15:0]), 56, 1'b0);
        2:    send_frame(mk(hdr, r1[7:0], r2[23:0], r3[15:0]), 56, 1'b0);
        3: begin
          n = $urandom_range(1, 55);
          f = mk(8'hA5, r1[7:0], r2[23:0], r3[15:0]);
          send_frame(f >> (56 - n), n, 1'b0);
        end
        default: begin
          n = $urandom_range(57, 62);
          f = mk(8'hA5, r1[7:0], r2[23:0], r3[15:0]);
          send_frame((f << (n - 56)) | 64'(r2[31:26] & 6'((1 << (n - 56)) - 1)), n, 1'b0);
        end
      endcase
    end

    f = mk(8'hA5, 8'h01, 24'h002710, 16'h0100);
    spi_cs_n = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      spi_mosi = f[55-i];
      repeat (HALF) @(posedge clk);
      #1;
      spi_sck = 1'b1;
      repeat (HALF) @(posedge clk);
      #1;
      spi_sck = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("t6_reset_pic", pic_dat, 0);
    check("t6_reset_amp", amp_dat, 0);
    check("t6_reset_spi_ok", SPI_OK, 0);
    spi_cs_n = 1'b1;
    model_reset();
    exp_q.delete();
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    send_frame(f, 56, 1'b1);
    check("t6_amp", amp_dat, 16'h0100);
    send_frame(mk(8'hA5, 8'h03, 24'h000001, 16'h0002), 56, 1'b0);

    repeat (20) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
